// File: rtl/cam_frame_writer_pkg.sv
// Shared types and default QVGA geometry for the OV7670 frame writer.
package cam_frame_writer_pkg;

  localparam int QVGA_H_ACTIVE = 320;
  localparam int QVGA_V_ACTIVE = 240;
  localparam int QVGA_ADDR_W   = $clog2(QVGA_H_ACTIVE * QVGA_V_ACTIVE);

  // Frame capture states: wait for a first blanking interval, blank, capture.
  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    BLANK     = 2'd1,
    ACTIVE    = 2'd2
  } state_e;

endpackage

// File: rtl/cam_frame_writer_if.sv
// Camera input bus plus frame-buffer write port of the frame writer.
interface cam_frame_writer_if
  import cam_frame_writer_pkg::*;
#(
  parameter int H_ACTIVE = QVGA_H_ACTIVE,
  parameter int V_ACTIVE = QVGA_V_ACTIVE
) ();

  localparam int AW = $clog2(H_ACTIVE * V_ACTIVE);

  // Camera side
  logic          href;
  logic          v_sync;
  logic [7:0]    data;
  // Frame-buffer side
  logic          we;
  logic [AW-1:0] wAddr;
  logic [15:0]   wData;
  // Status
  logic          frame_done;
  logic          line_err;

  // The frame writer itself
  modport slave (
    input  href, v_sync, data,
    output we, wAddr, wData, frame_done, line_err
  );

  // Camera model / frame-buffer observer
  modport master (
    output href, v_sync, data,
    input  we, wAddr, wData, frame_done, line_err
  );

endinterface

// File: rtl/rgb565_byte_assembler.sv
// Pairs consecutive camera bytes into one RGB565 pixel, high byte first.
module rgb565_byte_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic        pix_valid_o,
  output logic [15:0] pix_o
);

  logic       phase_q;
  logic [7:0] hi_q;

  // Toggle the byte phase while enabled; any gap drops a dangling high byte.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      phase_q <= 1'b0;
      hi_q    <= 8'h00;
    end else if (!en_i) begin
      phase_q <= 1'b0;
    end else begin
      if (!phase_q) hi_q <= data_i;
      phase_q <= ~phase_q;
    end
  end

  // The low byte is on the bus in the same cycle the pixel completes.
  assign pix_valid_o = en_i & phase_q;
  assign pix_o       = {hi_q, data_i};

endmodule

// File: rtl/cam_frame_writer.sv
// OV7670 RGB565 capture into a linear frame buffer, one write per pixel.
module cam_frame_writer
  import cam_frame_writer_pkg::*;
#(
  parameter int H_ACTIVE = QVGA_H_ACTIVE,
  parameter int V_ACTIVE = QVGA_V_ACTIVE
) (
  input logic               clk,
  input logic               reset,
  cam_frame_writer_if.slave bus
);

  localparam int AW = $clog2(H_ACTIVE * V_ACTIVE);
  localparam int PW = $clog2(H_ACTIVE + 1);
  localparam int LW = $clog2(V_ACTIVE + 1);

  localparam logic [PW-1:0] PIX_MAX   = PW'(H_ACTIVE);
  localparam logic [LW-1:0] LINE_MAX  = LW'(V_ACTIVE);
  localparam logic [AW-1:0] LINE_STEP = AW'(H_ACTIVE);

  state_e        state_q;
  logic [PW-1:0] pix_cnt_q;
  logic [LW-1:0] line_cnt_q;
  logic [AW-1:0] line_base_q;
  logic          href_q;
  logic          we_q;
  logic [AW-1:0] waddr_q;
  logic [15:0]   wdata_q;
  logic          frame_done_q;
  logic          line_err_q;

  logic          asm_en;
  logic          pix_valid;
  logic [15:0]   pix;
  logic          pix_in_range;
  logic          line_in_range;
  logic          line_end;
  logic [AW-1:0] addr_d;

  // Bytes only count while capturing; a rising v_sync kills a pending byte.
  assign asm_en = (state_q == ACTIVE) && bus.href && !bus.v_sync;

  rgb565_byte_assembler u_asm (
    .clk         (clk),
    .reset       (reset),
    .en_i        (asm_en),
    .data_i      (bus.data),
    .pix_valid_o (pix_valid),
    .pix_o       (pix)
  );

  assign pix_in_range  = pix_cnt_q < PIX_MAX;
  assign line_in_range = line_cnt_q < LINE_MAX;
  assign line_end      = href_q && !bus.href;
  // Base stepped by H_ACTIVE per line keeps the address free of a multiplier;
  // only used while both counters are in range, so it never exceeds the frame.
  assign addr_d        = line_base_q + AW'(pix_cnt_q);

  // Frame FSM with counters and registered frame-buffer outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= SYNC_WAIT;
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      line_base_q  <= '0;
      href_q       <= 1'b0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;
    end else begin
      we_q         <= 1'b0;
      frame_done_q <= 1'b0;
      // Edge history is only meaningful inside a frame.
      href_q       <= (state_q == ACTIVE) && bus.href;

      case (state_q)
        SYNC_WAIT: begin
          if (bus.v_sync) state_q <= BLANK;
        end

        BLANK: begin
          pix_cnt_q   <= '0;
          line_cnt_q  <= '0;
          line_base_q <= '0;
          if (!bus.v_sync) state_q <= ACTIVE;
        end

        ACTIVE: begin
          if (bus.v_sync) begin
            state_q      <= BLANK;
            frame_done_q <= (line_cnt_q == LINE_MAX);
          end else begin
            if (pix_valid) begin
              if (pix_in_range && line_in_range) begin
                we_q    <= 1'b1;
                waddr_q <= addr_d;
                wdata_q <= pix;
              end
              if (pix_in_range) pix_cnt_q <= pix_cnt_q + PW'(1);
            end
            if (line_end) begin
              if (pix_in_range) line_err_q <= 1'b1;
              pix_cnt_q <= '0;
              if (line_in_range) begin
                line_cnt_q  <= line_cnt_q + LW'(1);
                line_base_q <= line_base_q + LINE_STEP;
              end
            end
          end
        end

        default: state_q <= SYNC_WAIT;
      endcase
    end
  end

  assign bus.we         = we_q;
  assign bus.wAddr      = waddr_q;
  assign bus.wData      = wdata_q;
  assign bus.frame_done = frame_done_q;
  assign bus.line_err   = line_err_q;

endmodule

// File: tb/tb_cam_frame_writer.sv
// Directed bench: QVGA instance for line behaviour, a 12x5 instance for whole frames.
module tb_cam_frame_writer;
  import cam_frame_writer_pkg::*;

  localparam int SH   = 12;
  localparam int SV   = 5;
  localparam int M_AW = QVGA_ADDR_W;
  localparam int S_AW = $clog2(SH * SV);

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       href   = 1'b0;
  logic       v_sync = 1'b0;
  logic [7:0] data   = 8'h00;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [M_AW-1:0] m_addr_q[$];
  logic [15:0]     m_data_q[$];
  int              m_fd_cnt = 0;
  logic [S_AW-1:0] s_addr_q[$];
  logic [15:0]     s_data_q[$];
  int              s_fd_cnt = 0;

  cam_frame_writer_if #(.H_ACTIVE(QVGA_H_ACTIVE), .V_ACTIVE(QVGA_V_ACTIVE)) bus_m ();
  cam_frame_writer_if #(.H_ACTIVE(SH), .V_ACTIVE(SV)) bus_s ();

  assign bus_m.href   = href;
  assign bus_m.v_sync = v_sync;
  assign bus_m.data   = data;
  assign bus_s.href   = href;
  assign bus_s.v_sync = v_sync;
  assign bus_s.data   = data;

  cam_frame_writer #(.H_ACTIVE(QVGA_H_ACTIVE), .V_ACTIVE(QVGA_V_ACTIVE)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_m)
  );

  cam_frame_writer #(.H_ACTIVE(SH), .V_ACTIVE(SV)) u_small (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s)
  );

  always #5 clk = ~clk;

  // Log every frame-buffer write and frame_done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus_m.we === 1'b1) begin
      m_addr_q.push_back(bus_m.wAddr);
      m_data_q.push_back(bus_m.wData);
    end
    if (bus_m.frame_done === 1'b1) m_fd_cnt++;
    if (bus_s.we === 1'b1) begin
      s_addr_q.push_back(bus_s.wAddr);
      s_data_q.push_back(bus_s.wData);
    end
    if (bus_s.frame_done === 1'b1) s_fd_cnt++;
  end

  // Drive one cycle of camera bus, then move to the next falling edge.
  task automatic step(input logic h, input logic v, input logic [7:0] d);
    href   = h;
    v_sync = v;
    data   = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic v);
    repeat (n) step(1'b0, v, 8'h00);
  endtask

  task automatic clear_log();
    m_addr_q.delete();
    m_data_q.delete();
    s_addr_q.delete();
    s_data_q.delete();
    m_fd_cnt = 0;
    s_fd_cnt = 0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle(2, 1'b0);
    reset = 1'b0;
    idle(1, 1'b0);
    clear_log();
  endtask

  // Full v_sync high->low cycle: leaves the writers in ACTIVE at line 0.
  task automatic frame_start();
    idle(3, 1'b1);
    idle(3, 1'b0);
  endtask

  task automatic send_line(input int nbytes, input logic [7:0] hi, input logic [7:0] lo);
    for (int b = 0; b < nbytes; b++) step(1'b1, 1'b0, (b % 2 == 0) ? hi : lo);
    idle(3, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(1'b1, 1'b1, 8'hFF);
    step(1'b0, 1'b0, 8'h00);
    vec_cnt++;
    if (bus_m.we !== 1'b0) begin err_cnt++; $display("FAIL reset_we: got %b want 0", bus_m.we); end
    vec_cnt++;
    if (bus_m.wAddr !== '0) begin err_cnt++; $display("FAIL reset_waddr: got %0d want 0", bus_m.wAddr); end
    vec_cnt++;
    if (bus_m.wData !== 16'h0000) begin err_cnt++; $display("FAIL reset_wdata: got %h want 0000", bus_m.wData); end
    vec_cnt++;
    if (bus_m.frame_done !== 1'b0) begin err_cnt++; $display("FAIL reset_frame_done: got %b want 0", bus_m.frame_done); end
    vec_cnt++;
    if (bus_m.line_err !== 1'b0) begin err_cnt++; $display("FAIL reset_line_err: got %b want 0", bus_m.line_err); end
    reset = 1'b0;
    idle(1, 1'b0);
  endtask

  task automatic test_reset_midframe();
    apply_reset();
    frame_start();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 8'hC3);
      step(1'b1, 1'b0, 8'h3C);
    end
    vec_cnt++;
    if (bus_m.we !== 1'b1 || bus_m.wAddr !== M_AW'(4) || bus_m.wData !== 16'hC33C) begin
      err_cnt++;
      $display("FAIL midframe_pre: we=%b addr=%0d data=%h want 1/4/c33c", bus_m.we, bus_m.wAddr, bus_m.wData);
    end
    step(1'b1, 1'b0, 8'hC3);
    reset = 1'b1;
    #1;
    vec_cnt++;
    if (bus_m.we !== 1'b0 || bus_m.wAddr !== '0 || bus_m.wData !== 16'h0000) begin
      err_cnt++;
      $display("FAIL midframe_async_reset: we=%b addr=%0d data=%h want 0/0/0000", bus_m.we, bus_m.wAddr, bus_m.wData);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 8'h77);
      step(1'b0, 1'b0, 8'h00);
    end
    reset = 1'b0;
    clear_log();
    for (int l = 0; l < 3; l++) begin
      for (int b = 0; b < 10; b++) step(1'b1, 1'b0, 8'h5A);
      idle(2, 1'b0);
    end
    vec_cnt++;
    if (m_addr_q.size() != 0) begin err_cnt++; $display("FAIL midframe_no_we: got %0d writes want 0", m_addr_q.size()); end
    idle(3, 1'b1);
    vec_cnt++;
    if (m_addr_q.size() != 0) begin err_cnt++; $display("FAIL midframe_vsync_high: got %0d writes want 0", m_addr_q.size()); end
    idle(2, 1'b0);
    send_line(8, 8'h0F, 8'hF0);
    vec_cnt++;
    if (m_addr_q.size() != 4 || m_addr_q[0] !== '0 || m_data_q[0] !== 16'h0FF0) begin
      err_cnt++;
      $display("FAIL midframe_resume: n=%0d addr0=%0d data0=%h want 4/0/0ff0", m_addr_q.size(), m_addr_q[0], m_data_q[0]);
    end
  endtask

  task automatic test_single_line();
    bit ok;
    apply_reset();
    frame_start();
    for (int i = 0; i < QVGA_H_ACTIVE; i++) begin
      step(1'b1, 1'b0, 8'hF8);
      ok = (bus_m.we === 1'b0);
      step(1'b1, 1'b0, 8'h00);
      ok = ok && (bus_m.we === 1'b1) && (bus_m.wAddr === M_AW'(i)) && (bus_m.wData === 16'hF800);
      vec_cnt++;
      if (!ok) begin
        err_cnt++;
        $display("FAIL line_pixel[%0d]: we=%b addr=%0d data=%h want 1/%0d/f800", i, bus_m.we, bus_m.wAddr, bus_m.wData, i);
      end
    end
    step(1'b0, 1'b0, 8'h55);
    vec_cnt++;
    if (bus_m.we !== 1'b0 || bus_m.wAddr !== M_AW'(319) || bus_m.wData !== 16'hF800) begin
      err_cnt++;
      $display("FAIL line_hold: we=%b addr=%0d data=%h want 0/319/f800", bus_m.we, bus_m.wAddr, bus_m.wData);
    end
    idle(2, 1'b0);
    vec_cnt++;
    if (m_addr_q.size() != 320 || bus_m.line_err !== 1'b0) begin
      err_cnt++;
      $display("FAIL line_count: n=%0d line_err=%b want 320/0", m_addr_q.size(), bus_m.line_err);
    end
    idle(3, 1'b1);
    vec_cnt++;
    if (m_fd_cnt != 0) begin err_cnt++; $display("FAIL line_no_frame_done: got %0d want 0", m_fd_cnt); end
  endtask

  task automatic test_long_short();
    apply_reset();
    frame_start();
    send_line(660, 8'h12, 8'h34);
    vec_cnt++;
    if (m_addr_q.size() != 320 || m_addr_q[$] !== M_AW'(319) || m_data_q[$] !== 16'h1234 || bus_m.line_err !== 1'b0) begin
      err_cnt++;
      $display("FAIL long_line: n=%0d last=%0d data=%h err=%b want 320/319/1234/0",
               m_addr_q.size(), m_addr_q[$], m_data_q[$], bus_m.line_err);
    end
    clear_log();
    send_line(600, 8'h56, 8'h78);
    vec_cnt++;
    if (m_addr_q.size() != 300 || m_addr_q[0] !== M_AW'(320) || m_addr_q[$] !== M_AW'(619) || m_data_q[$] !== 16'h5678) begin
      err_cnt++;
      $display("FAIL short_line: n=%0d first=%0d last=%0d data=%h want 300/320/619/5678",
               m_addr_q.size(), m_addr_q[0], m_addr_q[$], m_data_q[$]);
    end
    vec_cnt++;
    if (bus_m.line_err !== 1'b1) begin err_cnt++; $display("FAIL short_line_err: got %b want 1", bus_m.line_err); end
    clear_log();
    send_line(640, 8'h9A, 8'hBC);
    vec_cnt++;
    if (m_addr_q.size() != 320 || m_addr_q[0] !== M_AW'(640) || bus_m.line_err !== 1'b1) begin
      err_cnt++;
      $display("FAIL line_err_sticky: n=%0d first=%0d err=%b want 320/640/1", m_addr_q.size(), m_addr_q[0], bus_m.line_err);
    end
  endtask

  task automatic test_odd_bytes();
    apply_reset();
    frame_start();
    send_line(7, 8'hAB, 8'hCD);
    vec_cnt++;
    if (m_addr_q.size() != 3 || m_addr_q[0] !== '0 || m_addr_q[2] !== M_AW'(2) || m_data_q[2] !== 16'hABCD) begin
      err_cnt++;
      $display("FAIL odd_writes: n=%0d a0=%0d a2=%0d d2=%h want 3/0/2/abcd", m_addr_q.size(), m_addr_q[0], m_addr_q[2], m_data_q[2]);
    end
    clear_log();
    send_line(4, 8'h11, 8'h22);
    vec_cnt++;
    if (m_addr_q.size() != 2 || m_addr_q[0] !== M_AW'(320) || m_data_q[0] !== 16'h1122) begin
      err_cnt++;
      $display("FAIL odd_next_line: n=%0d a0=%0d d0=%h want 2/320/1122", m_addr_q.size(), m_addr_q[0], m_data_q[0]);
    end
  endtask

  task automatic test_abort();
    apply_reset();
    frame_start();
    for (int l = 0; l < 100; l++) send_line(2, 8'(l), 8'h00);
    vec_cnt++;
    if (m_addr_q.size() != 100 || m_addr_q[$] !== M_AW'(99 * 320)) begin
      err_cnt++;
      $display("FAIL abort_lines: n=%0d last=%0d want 100/31680", m_addr_q.size(), m_addr_q[$]);
    end
    clear_log();
    step(1'b1, 1'b0, 8'h99);
    step(1'b1, 1'b1, 8'h88);
    idle(3, 1'b1);
    vec_cnt++;
    if (m_addr_q.size() != 0 || m_fd_cnt != 0) begin
      err_cnt++;
      $display("FAIL abort_vsync: writes=%0d frame_done=%0d want 0/0", m_addr_q.size(), m_fd_cnt);
    end
    idle(2, 1'b0);
    send_line(4, 8'h21, 8'h43);
    vec_cnt++;
    if (m_addr_q.size() != 2 || m_addr_q[0] !== '0 || m_addr_q[1] !== M_AW'(1) || m_data_q[0] !== 16'h2143) begin
      err_cnt++;
      $display("FAIL abort_restart: n=%0d a0=%0d a1=%0d d0=%h want 2/0/1/2143", m_addr_q.size(), m_addr_q[0], m_addr_q[1], m_data_q[0]);
    end
  endtask

  task automatic test_full_frame();
    bit seq_ok;
    apply_reset();
    frame_start();
    for (int l = 0; l < SV; l++) send_line(2 * SH, 8'(l), 8'(8'h40 + l));
    send_line(2 * SH, 8'hEE, 8'hEE);
    seq_ok = (s_addr_q.size() == SH * SV);
    for (int i = 0; i < s_addr_q.size(); i++) if (s_addr_q[i] !== S_AW'(i)) seq_ok = 1'b0;
    vec_cnt++;
    if (!seq_ok) begin
      err_cnt++;
      $display("FAIL frame_addr_seq: n=%0d last=%0d want 60 writes at 0..59", s_addr_q.size(), s_addr_q[$]);
    end
    vec_cnt++;
    if (s_addr_q[$] !== S_AW'(SH * SV - 1) || s_data_q[$] !== 16'h0444) begin
      err_cnt++;
      $display("FAIL frame_last: addr=%0d data=%h want 59/0444", s_addr_q[$], s_data_q[$]);
    end
    vec_cnt++;
    if (s_fd_cnt != 0) begin err_cnt++; $display("FAIL frame_done_early: got %0d want 0", s_fd_cnt); end
    idle(4, 1'b1);
    vec_cnt++;
    if (s_fd_cnt != 1) begin err_cnt++; $display("FAIL frame_done_once: got %0d want 1", s_fd_cnt); end
    vec_cnt++;
    if (bus_s.line_err !== 1'b0) begin err_cnt++; $display("FAIL frame_line_err: got %b want 0", bus_s.line_err); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_reset_midframe();
    test_single_line();
    test_long_short();
    test_odd_bytes();
    test_abort();
    test_full_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cam_frame_writer.md
CAM_FRAME_WRITER -- requirements
Module: cam_frame_writer

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 320, pixels stored per line.
REQ-002 SHALL have parameter V_ACTIVE, default 240, lines stored per frame.
REQ-003 SHALL have port clk, input, 1, OV7670 pixel clock (PCLK); all logic on rising edge; one clock only.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port href, input, 1, camera line-valid.
REQ-006 SHALL have port v_sync, input, 1, camera frame sync; high = vertical blanking.
REQ-007 SHALL have port data, input, 8, camera byte bus; RGB565, high byte first.
REQ-008 SHALL have port we, output, 1, frame-buffer write enable, one-cycle pulse per pixel.
REQ-009 SHALL have port wAddr, output, $clog2(H_ACTIVE*V_ACTIVE), frame-buffer write address.
REQ-010 SHALL have port wData, output, 16, RGB565 pixel {R[4:0],G[5:0],B[4:0]}.
REQ-011 SHALL have port frame_done, output, 1, one-cycle pulse at end of each fully written frame.
REQ-012 SHALL have port line_err, output, 1, sticky flag: a line had fewer than H_ACTIVE pixels.

Function
REQ-013 SHALL implement FSM states SYNC_WAIT, BLANK, ACTIVE.
REQ-014 SYNC_WAIT: after reset, write nothing; go to BLANK when v_sync is sampled high (discards any partial frame).
REQ-015 BLANK: clear pixel, line and address counters; go to ACTIVE when v_sync is sampled low.
REQ-016 ACTIVE: capture pixels; go to BLANK when v_sync is sampled high; frame_done pulses in that same transition cycle only if line count reached V_ACTIVE.
REQ-017 Byte phase toggles on each clk with href high: phase 0 latches data into wData[15:8], phase 1 into wData[7:0].
REQ-018 Phase SHALL return to 0 whenever href is sampled low; a dangling odd byte is dropped and not written.
REQ-019 On a phase-1 byte with pixel index < H_ACTIVE and line index < V_ACTIVE, we SHALL be 1 in the next cycle, with wAddr/wData valid in that same cycle (latency one clk from second byte).
REQ-020 Address = line_base + pixel index, where line_base advances by H_ACTIVE per line; no multiplier.
REQ-021 Pixels with index >= H_ACTIVE and lines with index >= V_ACTIVE SHALL be suppressed (we=0); counters saturate and do not wrap.
REQ-022 Line index SHALL increment on href falling edge (sampled high then low) in ACTIVE.
REQ-023 If a line ends with pixel index < H_ACTIVE, line_err SHALL set and hold until reset; the line still advances.
REQ-024 wAddr never exceeds H_ACTIVE*V_ACTIVE-1.
REQ-025 If v_sync rises while href is high, the FSM SHALL take BLANK immediately; a pending phase-0 byte is dropped.
REQ-026 wAddr and wData SHALL hold their last values when we=0.

Reset
REQ-027 On reset: we=0, wAddr=0, wData=0, frame_done=0, line_err=0, all counters 0, phase=0, FSM=SYNC_WAIT.
REQ-028 Reset asserted mid-frame SHALL abort immediately; capture resumes only after a full v_sync high->low cycle.

Structure
REQ-029 A shared package SHALL hold the FSM state enum and the default QVGA constants (320, 240, address width).
REQ-030 The block SHALL be one module, with an optional sub-module rgb565_byte_assembler (phase toggle plus 16-bit assembly).

Verification
REQ-031 Release reset mid-frame with v_sync low and href toggling -> no we until v_sync goes 1->0.
REQ-032 One line of 320 pixels, bytes 0xF8,0x00 repeated -> 320 we pulses, wData=0xF800, wAddr 0..319, one clk after each second byte.
REQ-033 Full 320x240 frame, then v_sync high -> last wAddr=76799, frame_done pulses exactly once, line_err=0.
REQ-034 Line of 330 pixels, then a line of 300 pixels -> first line writes 320 only; second line writes addr 320..619; line_err=1 and stays 1.
REQ-035 href drops after an odd byte count (7 bytes) -> 3 writes; next line starts on a high byte at the next line_base.
REQ-036 v_sync rises at line 100 -> no frame_done; next frame restarts at wAddr=0.
